// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sprite_pkg
// Purpose  : Shared types, default sizes and the image-size check for the
//            sprite RAM loader.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int MAX_WORDS = 32768;
    localparam int DIM_W     = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_GET_CNT = 3'd2,
        ST_GET_VAL = 3'd3,
        ST_EXPAND  = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pixel_t;

    // Only evaluated once per start command, so a full multiply is fine here.
    function automatic logic area_exceeds(input logic [DIM_W-1:0] w,
                                          input logic [DIM_W-1:0] h,
                                          input int               max_words);
        logic [2*DIM_W-1:0] area;
        area = {{DIM_W{1'b0}}, w} * {{DIM_W{1'b0}}, h};
        return 32'(area) > max_words;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : sprite_mem_loader_if
// Purpose   : Pixel byte stream (valid/ready) plus sprite RAM port-A write bus.
// Revision  : 1.0 - initial release
// ============================================================================
interface sprite_mem_loader_if #(
    parameter int ADDR_W = sprite_pkg::ADDR_W,
    parameter int DATA_W = sprite_pkg::DATA_W
);
    import sprite_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;

    // master is the loader: it consumes the stream and drives the RAM port
    modport master (
        input  s_data,
        input  s_valid,
        output s_ready,
        output mem_addr,
        output mem_data,
        output mem_we
    );

    modport slave (
        output s_data,
        output s_valid,
        input  s_ready,
        input  mem_addr,
        input  mem_data,
        input  mem_we
    );

endinterface
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sprite_addr_gen
// Purpose  : Row-major x/y/address counters with clear, step and last-pixel
//            flag; the address is kept incrementally so no multiplier is used.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_addr_gen #(
    parameter int ADDR_W = sprite_pkg::ADDR_W,
    parameter int DIM_W  = sprite_pkg::DIM_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_clear,
    input  wire logic              i_step,
    input  wire logic [DIM_W-1:0]  i_width,
    input  wire logic [DIM_W-1:0]  i_height,
    output logic      [DIM_W-1:0]  o_x,
    output logic      [DIM_W-1:0]  o_y,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last
);
    import sprite_pkg::*;

    localparam logic [DIM_W-1:0]  c_one_dim  = DIM_W'(1);
    localparam logic [ADDR_W-1:0] c_one_addr = ADDR_W'(1);

    logic [DIM_W-1:0]  r_x;
    logic [DIM_W-1:0]  r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              w_row_end;

    assign w_row_end = (r_x == (i_width - c_one_dim));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_step) begin
            r_addr <= r_addr + c_one_addr;
            if (w_row_end) begin
                r_x <= '0;
                r_y <= r_y + c_one_dim;
            end else begin
                r_x <= r_x + c_one_dim;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_addr = r_addr;
    assign o_last = w_row_end && (r_y == (i_height - c_one_dim));

endmodule
`default_nettype wire

// File: rtl/sprite_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : sprite_mem_loader
// Purpose  : Writes an RRRGGGBB byte stream row-major into sprite RAM port A.
//            Define SPRITE_RLE_EN to accept {count, value} run-length pairs.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_mem_loader #(
    parameter int ADDR_W    = sprite_pkg::ADDR_W,
    parameter int DATA_W    = sprite_pkg::DATA_W,
    parameter int MAX_WORDS = sprite_pkg::MAX_WORDS
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          start,
    input  wire logic [sprite_pkg::DIM_W-1:0]  width,
    input  wire logic [sprite_pkg::DIM_W-1:0]  height,
    sprite_mem_loader_if.master                bus,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic      [sprite_pkg::DIM_W-1:0]  cur_x,
    output logic      [sprite_pkg::DIM_W-1:0]  cur_y
);
    import sprite_pkg::*;

`ifdef SPRITE_RLE_EN
    localparam int              REM_W        = DATA_W + 1;
    localparam logic [REM_W-1:0] c_one_rem   = REM_W'(1);
    localparam logic [REM_W-1:0] c_full_run  = {1'b1, {DATA_W{1'b0}}};
    localparam state_t          c_load_state = ST_GET_CNT;
`else
    localparam state_t          c_load_state = ST_RUN;
`endif

    state_t            r_state;
    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;
    logic              r_we;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    logic              w_accept;
    logic              w_start_ok;
    logic              w_empty;
    logic              w_too_big;
    logic              w_emit;
    logic [DATA_W-1:0] w_emit_data;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;
    logic [DIM_W-1:0]  w_x;
    logic [DIM_W-1:0]  w_y;

    assign w_accept   = bus.s_valid & bus.s_ready;
    assign w_start_ok = start && (r_state == ST_IDLE);
    assign w_empty    = (width == '0) || (height == '0);
    assign w_too_big  = area_exceeds(width, height, MAX_WORDS);

`ifdef SPRITE_RLE_EN
    logic [REM_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_val;

    // The value byte itself produces the first pixel; EXPAND produces the rest.
    assign bus.s_ready = (r_state == ST_GET_CNT) || (r_state == ST_GET_VAL);
    assign w_emit      = ((r_state == ST_GET_VAL) && w_accept) || (r_state == ST_EXPAND);
    assign w_emit_data = (r_state == ST_EXPAND) ? r_val : bus.s_data;
`else
    assign bus.s_ready = (r_state == ST_RUN);
    assign w_emit      = w_accept;
    assign w_emit_data = bus.s_data;
`endif

    sprite_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_ok),
        .i_step   (w_emit),
        .i_width  (r_width),
        .i_height (r_height),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_addr   (w_addr),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_width    <= '0;
            r_height   <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
`ifdef SPRITE_RLE_EN
            r_rem      <= '0;
            r_val      <= '0;
`endif
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;

            if (w_emit) begin
                r_we       <= 1'b1;
                r_mem_addr <= w_addr;
                r_mem_data <= w_emit_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_width  <= width;
                        r_height <= height;
                        r_err    <= 1'b0;
                        if (w_empty) begin
                            r_done <= 1'b1;
                        end else if (w_too_big) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_state <= c_load_state;
                        end
                    end
                end
`ifndef SPRITE_RLE_EN
                ST_RUN: begin
                    if (w_accept && w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
`else
                ST_GET_CNT: begin
                    if (w_accept) begin
                        r_rem   <= (bus.s_data == '0) ? c_full_run : REM_W'(bus.s_data);
                        r_state <= ST_GET_VAL;
                    end
                end
                ST_GET_VAL, ST_EXPAND: begin
                    if (w_emit) begin
                        if (r_state == ST_GET_VAL) begin
                            r_val <= bus.s_data;
                        end
                        r_rem <= r_rem - c_one_rem;
                        // Image full: pixels still owed by this run are dropped.
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                            if (r_rem != c_one_rem) begin
                                r_err <= 1'b1;
                            end
                        end else if (r_rem == c_one_rem) begin
                            r_state <= ST_GET_CNT;
                        end else begin
                            r_state <= ST_EXPAND;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign cur_x        = w_x;
    assign cur_y        = w_y;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_mem_loader
// Purpose  : Randomized loads of sprite_mem_loader; a monitor matches every
//            RAM write / done pulse against a queue filled by the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_mem_loader;
    import sprite_pkg::*;

    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int DIM = 11;
    localparam int MAXW = 32768;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           start  = 1'b0;
    logic [DIM-1:0] width  = '0;
    logic [DIM-1:0] height = '0;
    logic           busy;
    logic           done;
    logic           err;
    logic [DIM-1:0] cur_x;
    logic [DIM-1:0] cur_y;

    sprite_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .width  (width),
        .height (height),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .cur_x  (cur_x),
        .cur_y  (cur_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit we;
        int addr;
        int data;
        bit dn;
        bit er;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  tog      = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input bit we, input int addr, input int data,
                                    input bit dn, input bit er);
        ev_t e;
        e.we = we; e.addr = addr; e.data = data; e.dn = dn; e.er = er;
        exp_q.push_back(e);
    endfunction

    // Every write strobe or done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event: we=%0b addr=0x%0h data=0x%0h done=%0b, expected no event",
                         bus.mem_we, bus.mem_addr, bus.mem_data, done);
            end else begin
                mon_e = exp_q.pop_front();
                check("mem_we", bus.mem_we, mon_e.we);
                if (mon_e.we) begin
                    check("mem_addr", bus.mem_addr, mon_e.addr);
                    check("mem_data", bus.mem_data, mon_e.data);
                end
                check("done", done, mon_e.dn);
                if (mon_e.dn) check("err_at_done", err, mon_e.er);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one cycle after the start edge.
    task automatic do_start(input int w, input int h, output bit ok);
        int area;
        area  = w * h;
        start = 1'b1;
        width = DIM'(w);
        height = DIM'(h);
        @(posedge clk); #1;
        start = 1'b0;
        ok = (area != 0) && (area <= MAXW);
        if (!ok) push_ev(1'b0, 0, 0, 1'b1, area != 0);
        @(negedge clk);
        check("busy_after_start", busy, ok);
        check("done_after_start", done, !ok);
        check("err_after_start", err, area > MAXW);
        if (ok) begin
            check("cur_x_start", cur_x, 0);
            check("cur_y_start", cur_y, 0);
        end
        @(posedge clk); #1;
    endtask

    // mode 0: valid always high, 1: alternating 1010, 2: random
    task automatic send_byte(input logic [7:0] d, input int mode, input bit noise, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 400) begin
            case (mode)
                0:       bus.s_valid = 1'b1;
                1:       begin bus.s_valid = tog; tog = ~tog; end
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            bus.s_data = bus.s_valid ? d : 8'($urandom);
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                width  = DIM'($urandom);
                height = DIM'($urandom);
            end
            @(negedge clk);
            ok = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.s_valid = 1'b0;
        start = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: byte 0x%0h not accepted within %0d cycles", d, guard);
        end
    endtask

    task automatic stream_plain(input int w, input int h, input int n, input int mode,
                                input bit seq_data, input bit noise);
        int area;
        bit ok;
        logic [7:0] d;
        area = w * h;
        for (int idx = 0; idx < n; idx++) begin
            d = seq_data ? 8'(idx + 1) : 8'($urandom);
            check("cur_x", cur_x, idx % w);
            check("cur_y", cur_y, idx / w);
            send_byte(d, mode, noise, ok);
            if (!ok) return;
            push_ev(1'b1, idx, d, idx == area - 1, 1'b0);
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: %0d expected events still pending", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_ready_idle"}, bus.s_ready, 0);
        @(posedge clk); #1;
    endtask

`ifdef SPRITE_RLE_EN
    // Expands pairs into expected writes, truncating at the image end.
    task automatic rle_load(input int w, input int h, input int cnts[$], input int vals[$]);
        int area;
        int pos;
        int n;
        bit ok;
        area = w * h;
        pos  = 0;
        do_start(w, h, ok);
        foreach (cnts[i]) begin
            n = (cnts[i] == 0) ? 256 : cnts[i];
            for (int k = 0; k < n; k++) begin
                if (pos < area) begin
                    push_ev(1'b1, pos, vals[i], pos == area - 1, k != n - 1);
                    pos++;
                end
            end
        end
        foreach (cnts[i]) begin
            send_byte(8'(cnts[i]), 2, 1'b0, ok);
            if (!ok) return;
            send_byte(8'(vals[i]), 2, 1'b0, ok);
            if (!ok) return;
        end
        drain("rle");
    endtask
`endif

    initial begin
        bit ok;
        int w;
        int h;
        int mode;
        bit noise;
`ifdef SPRITE_RLE_EN
        int cq[$];
        int vq[$];
        int sum;
        int c;
`endif
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data", bus.mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_cur_x", cur_x, 0);
        check("rst_cur_y", cur_y, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-size and oversize images finish without writing.
        do_start(0, 5, ok);
        drain("t3");
        do_start(344, 100, ok);
        @(negedge clk);
        check("err_sticky", err, 1);
        @(posedge clk); #1;
        do_start(257, 128, ok);
        drain("over_257x128");
        do_start(2047, 2047, ok);
        drain("over_max");

`ifndef SPRITE_RLE_EN
        do_start(4, 2, ok);
        stream_plain(4, 2, 8, 0, 1'b1, 1'b0);
        drain("t1");

        tog = 1'b1;
        do_start(4, 2, ok);
        stream_plain(4, 2, 8, 1, 1'b1, 1'b0);
        drain("t2");

        do_start(4, 2, ok);
        stream_plain(4, 2, 3, 0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_mem_we", bus.mem_we, 0);
        check("t5_busy", busy, 0);
        check("t5_s_ready", bus.s_ready, 0);
        @(posedge clk); #1;
        do_start(4, 2, ok);
        stream_plain(4, 2, 8, 2, 1'b0, 1'b0);
        drain("t5");

        // Back-to-back: new start issued in the done cycle.
        do_start(5, 1, ok);
        stream_plain(5, 1, 5, 0, 1'b0, 1'b0);
        do_start(2, 3, ok);
        stream_plain(2, 3, 6, 2, 1'b0, 1'b1);
        drain("b2b");

        repeat (8) begin
            w = $urandom_range(1, 24);
            h = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            noise = 1'($urandom_range(0, 1));
            do_start(w, h, ok);
            stream_plain(w, h, w * h, mode, 1'b0, noise);
            drain("rand");
        end

        // Largest legal image fills the whole RAM.
        do_start(256, 128, ok);
        stream_plain(256, 128, 256 * 128, 0, 1'b0, 1'b0);
        drain("full");
`else
        cq.delete(); vq.delete();
        cq.push_back(4); vq.push_back(8'hE0);
        cq.push_back(3); vq.push_back(8'h1C);
        rle_load(3, 2, cq, vq);

        repeat (6) begin
            w = $urandom_range(1, 10);
            h = $urandom_range(1, 6);
            cq.delete(); vq.delete();
            sum = 0;
            while (sum < w * h) begin
                c = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7);
                cq.push_back(c);
                vq.push_back($urandom_range(0, 255));
                sum += (c == 0) ? 256 : c;
            end
            rle_load(w, h, cq, vq);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
